rv_trap_ctrl: RTL

Trap and interrupt controller for the single-cycle RISC-V core. It sits between the decode/next-PC logic and the PC register. It arbitrates NUM_IRQ edge-triggered external interrupt lines plus the synchronous ecall, illegal-instruction and mret events. It owns mepc, mcause and a software-writable interrupt-enable mask, and it drives the architectural PC each cycle.

---
 rtl/rv_trap_ctrl_pkg.sv | 19 +
 rtl/rv_irq_prio_enc.sv | 23 ++
 rtl/rv_trap_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/rv_trap_ctrl_pkg.sv
// Shared definitions for the trap controller:
// cause codes, vector offsets and handler state.
package rv_trap_ctrl_pkg;

    localparam logic [31:0] CAUSE_ILL   = 32'd2;
    localparam logic [31:0] CAUSE_ECALL = 32'd11;
    localparam int          CAUSE_IRQ_BIT = 31;

    localparam logic [31:0] VEC_ILL    = 32'h04;
    localparam logic [31:0] VEC_ECALL  = 32'h08;
    localparam logic [31:0] VEC_IRQ    = 32'h0C;
    localparam logic [31:0] VEC_STRIDE = 32'h04;

    typedef enum logic {
        RUN        = 1'b0,
        IRQ_ACTIVE = 1'b1
    } trap_state_t;

endpackage

// File: rtl/rv_irq_prio_enc.sv
// Lowest-index-first priority encoder over
// the enabled pending interrupt vector.
module rv_irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   idx
);

    // scan high to low so the lowest set bit wins
    always_comb begin
        valid = 1'b0;
        idx   = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/rv_trap_ctrl.sv
// Trap/interrupt controller: arbitrates mret,
// exceptions and edge interrupts; owns pc/mepc/mcause.
module rv_trap_ctrl
    import rv_trap_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ   = 4,
    parameter logic [31:0] TVEC_BASE = 32'h00000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ecall,
    input  logic               mret,
    input  logic               ill_instr,
    input  logic [31:0]        pc_next,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [31:0]        pc,
    output logic [31:0]        mepc,
    output logic [31:0]        mcause,
    output logic [NUM_IRQ-1:0] irq_mask,
    output logic               in_irq,
    output logic               trap_taken
);

    trap_state_t        state_q;
    trap_state_t        state_d;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] clr;
    logic [31:0]        pc_d;
    logic [31:0]        mepc_d;
    logic [31:0]        mcause_d;
    logic               trap_d;
    logic               irq_vld;
    logic [3:0]         irq_idx;

    rv_irq_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio (
        .req   (pending_q & irq_mask),
        .valid (irq_vld),
        .idx   (irq_idx)
    );

    assign in_irq = (state_q == IRQ_ACTIVE);

    // one action per cycle, highest priority first
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_next;
        mepc_d   = mepc;
        mcause_d = mcause;
        trap_d   = 1'b0;
        clr      = '0;
        if (mret) begin
            pc_d    = mepc;
            state_d = RUN;
        end else if (ill_instr) begin
            mepc_d   = pc_next;
            mcause_d = CAUSE_ILL;
            pc_d     = TVEC_BASE + VEC_ILL;
            trap_d   = 1'b1;
        end else if (ecall) begin
            mepc_d   = pc_next;
            mcause_d = CAUSE_ECALL;
            pc_d     = TVEC_BASE + VEC_ECALL;
            trap_d   = 1'b1;
        end else if (irq_vld && state_q == RUN) begin
            mepc_d   = pc_next;
            mcause_d = {1'b1, 27'b0, irq_idx};
            pc_d     = TVEC_BASE + VEC_IRQ
                     + VEC_STRIDE * {28'b0, irq_idx};
            trap_d   = 1'b1;
            clr      = NUM_IRQ'(1) << irq_idx;
            state_d  = IRQ_ACTIVE;
        end
        // a new edge wins over a same-cycle clear
        pending_d = (pending_q & ~clr) | (irq & ~irq_d);
    end

    // architectural and handler state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            pending_q  <= '0;
            irq_d      <= '0;
            pc         <= '0;
            mepc       <= '0;
            mcause     <= '0;
            irq_mask   <= '0;
            trap_taken <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            irq_d      <= irq;
            pc         <= pc_d;
            mepc       <= mepc_d;
            mcause     <= mcause_d;
            trap_taken <= trap_d;
            if (mask_we) irq_mask <= mask_wdata;
        end
    end

endmodule
